// File: rtl/instr_loader.sv
// instr_loader: serial 9-bit instruction deserialiser with a small FIFO that issues
// words to the cpu core while it signals ready. Optional macro: LOADER_PARITY_EN.
`default_nettype none

module instr_loader #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          SER_IN,
  input  logic          SER_VALID,
  input  logic          FRAME_SYNC,
  input  logic          CPU_READY,
  output logic [8:0]    INSTRUCTION,
  output logic          write_en,
  output logic [AW:0]   FIFO_COUNT,
  output logic          FULL,
  output logic          OVERFLOW,
  output logic          PAR_ERR
);

  typedef enum logic {RX_IDLE = 1'b0, RX_SHIFT = 1'b1} rx_state_t;

`ifdef LOADER_PARITY_EN
  localparam logic [3:0] c_LAST_CNT = 4'd9;
`else
  localparam logic [3:0] c_LAST_CNT = 4'd8;
`endif
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  rx_state_t   r_state;
  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_shreg;
  logic [8:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0] r_count;
  logic        r_full;
  logic        r_ovf;
  logic [8:0]  r_instr;
  logic        r_we;

  logic        w_last;
  logic [8:0]  w_word;
  logic        w_par_ok;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_count_nxt;

  // Counter holds the number of bits already received, so the frame ends on the bit
  // that arrives while it equals c_LAST_CNT.
  assign w_last = (r_state == RX_SHIFT) && SER_VALID && !FRAME_SYNC &&
                  (r_bit_cnt == c_LAST_CNT);

`ifdef LOADER_PARITY_EN
  assign w_word   = r_shreg;
  assign w_par_ok = ^{r_shreg, SER_IN};
`else
  assign w_word   = {r_shreg[7:0], SER_IN};
  assign w_par_ok = 1'b1;
`endif

  assign w_pop      = (r_count != '0) && CPU_READY;
  assign w_push_req = w_last && w_par_ok;
  assign w_push     = w_push_req && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= RX_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (FRAME_SYNC) begin
      r_state   <= RX_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (SER_VALID) begin
      r_shreg <= {r_shreg[7:0], SER_IN};
      if (r_state == RX_IDLE) begin
        r_state   <= RX_SHIFT;
        r_bit_cnt <= 4'd1;
      end else if (w_last) begin
        r_state   <= RX_IDLE;
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  // Storage has no reset; contents are only observed through valid pointers.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_tail] <= w_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_instr <= '0;
      r_we    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_DEPTH);
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_push_req && r_full && !w_pop) r_ovf <= 1'b1;
      if (w_pop) begin
        r_instr <= r_mem[r_head];
        r_head  <= r_head + AW'(1);
        r_we    <= 1'b1;
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

`ifdef LOADER_PARITY_EN
  logic r_par_err;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)               r_par_err <= 1'b0;
    else if (w_last && !w_par_ok) r_par_err <= 1'b1;
  end

  assign PAR_ERR = r_par_err;
`else
  assign PAR_ERR = 1'b0;
`endif

  assign INSTRUCTION = r_instr;
  assign write_en    = r_we;
  assign FIFO_COUNT  = r_count;
  assign FULL        = r_full;
  assign OVERFLOW    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed self-checking bench for instr_loader (DEPTH = 4).
`default_nettype none

module tb_instr_loader;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SER_IN = 1'b0;
  logic       SER_VALID = 1'b0;
  logic       FRAME_SYNC = 1'b0;
  logic       CPU_READY = 1'b0;
  logic [8:0] INSTRUCTION;
  logic       write_en;
  logic [2:0] FIFO_COUNT;
  logic       FULL;
  logic       OVERFLOW;
  logic       PAR_ERR;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  instr_loader #(.DEPTH(4), .AW(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SER_IN(SER_IN), .SER_VALID(SER_VALID),
    .FRAME_SYNC(FRAME_SYNC), .CPU_READY(CPU_READY), .INSTRUCTION(INSTRUCTION),
    .write_en(write_en), .FIFO_COUNT(FIFO_COUNT), .FULL(FULL),
    .OVERFLOW(OVERFLOW), .PAR_ERR(PAR_ERR)
  );

  always #5 CLK = ~CLK;

  // A write_en pulse spans one full period, so each pulse is seen on exactly one negedge.
  always @(negedge CLK) if (write_en === 1'b1) we_cnt++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_raw(input logic [9:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SER_IN    = b[i];
      SER_VALID = 1'b1;
      tick();
    end
    SER_VALID = 1'b0;
    SER_IN    = 1'b0;
  endtask

  task automatic shift_frame(input logic [8:0] w, input bit ready_on_last);
    logic [9:0] bits;
    int n;
`ifdef LOADER_PARITY_EN
    bits = {w, ~^w};
    n    = 10;
`else
    bits = {1'b0, w};
    n    = 9;
`endif
    shift_raw(bits >> 1, n - 1);
    if (ready_on_last) CPU_READY = 1'b1;
    shift_raw(bits, 1);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; SER_IN = 1'b0; SER_VALID = 1'b0; FRAME_SYNC = 1'b0; CPU_READY = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; CPU_READY = 1'b0; SER_VALID = 1'b0;
    tick(); tick();
    checks++;
    if ({INSTRUCTION, write_en, FIFO_COUNT, FULL, OVERFLOW, PAR_ERR} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got instr=%h we=%b cnt=%0d full=%b ovf=%b perr=%b, want all 0",
               INSTRUCTION, write_en, FIFO_COUNT, FULL, OVERFLOW, PAR_ERR);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base;
    do_reset();
    CPU_READY = 1'b1;
    base = we_cnt;
    shift_frame(9'h1A5, 1'b0);
    checks++;
    if (write_en !== 1'b0 || FIFO_COUNT !== 3'd1) begin
      errors++;
      $display("FAIL single_push: got we=%b cnt=%0d, want we=0 cnt=1", write_en, FIFO_COUNT);
    end
    tick();
    checks++;
    if (write_en !== 1'b1 || INSTRUCTION !== 9'h1A5 || FIFO_COUNT !== 3'd0) begin
      errors++;
      $display("FAIL single_issue: got we=%b instr=%h cnt=%0d, want we=1 instr=1a5 cnt=0",
               write_en, INSTRUCTION, FIFO_COUNT);
    end
    tick(); tick();
    checks++;
    if (write_en !== 1'b0 || INSTRUCTION !== 9'h1A5 || (we_cnt - base) !== 1) begin
      errors++;
      $display("FAIL single_once: got we=%b instr=%h pulses=%0d, want we=0 instr=1a5 pulses=1",
               write_en, INSTRUCTION, we_cnt - base);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] exp;
    do_reset();
    for (int f = 0; f < 5; f++) shift_frame(9'h101 + 9'(f), 1'b0);
    checks++;
    if (FULL !== 1'b1 || OVERFLOW !== 1'b1 || FIFO_COUNT !== 3'd4 || write_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state: got full=%b ovf=%b cnt=%0d we=%b, want 1 1 4 0",
               FULL, OVERFLOW, FIFO_COUNT, write_en);
    end
    CPU_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 9'h101 + 9'(i);
      checks++;
      if (write_en !== 1'b1 || INSTRUCTION !== exp || FIFO_COUNT !== 3'(3 - i) || FULL !== 1'b0) begin
        errors++;
        $display("FAIL ovf_drain%0d: got we=%b instr=%h cnt=%0d full=%b, want 1 %h %0d 0",
                 i, write_en, INSTRUCTION, FIFO_COUNT, FULL, exp, 3 - i);
      end
    end
    tick();
    checks++;
    if (write_en !== 1'b0 || INSTRUCTION !== 9'h104 || OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL ovf_lost: got we=%b instr=%h ovf=%b, want 0 104 1", write_en, INSTRUCTION, OVERFLOW);
    end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] exp [4];
    exp[0] = 9'h022; exp[1] = 9'h033; exp[2] = 9'h044; exp[3] = 9'h155;
    do_reset();
    shift_frame(9'h011, 1'b0);
    for (int i = 0; i < 3; i++) shift_frame(exp[i], 1'b0);
    checks++;
    if (FULL !== 1'b1 || FIFO_COUNT !== 3'd4) begin
      errors++;
      $display("FAIL fpp_full: got full=%b cnt=%0d, want 1 4", FULL, FIFO_COUNT);
    end
    shift_frame(exp[3], 1'b1);
    checks++;
    if (write_en !== 1'b1 || INSTRUCTION !== 9'h011 || FIFO_COUNT !== 3'd4 ||
        FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL fpp_same_edge: got we=%b instr=%h cnt=%0d full=%b ovf=%b, want 1 011 4 1 0",
               write_en, INSTRUCTION, FIFO_COUNT, FULL, OVERFLOW);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (write_en !== 1'b1 || INSTRUCTION !== exp[i] || FIFO_COUNT !== 3'(3 - i)) begin
        errors++;
        $display("FAIL fpp_order%0d: got we=%b instr=%h cnt=%0d, want 1 %h %0d",
                 i, write_en, INSTRUCTION, FIFO_COUNT, exp[i], 3 - i);
      end
    end
  endtask

  task automatic test_frame_sync();
    int base;
    do_reset();
    CPU_READY = 1'b1;
    base = we_cnt;
    shift_raw(10'b10110, 5);
    FRAME_SYNC = 1'b1;
    SER_IN = 1'b1; SER_VALID = 1'b1;
    tick();
    FRAME_SYNC = 1'b0; SER_VALID = 1'b0; SER_IN = 1'b0;
    shift_frame(9'h0F0, 1'b0);
    tick();
    checks++;
    if (write_en !== 1'b1 || INSTRUCTION !== 9'h0F0) begin
      errors++;
      $display("FAIL sync_issue: got we=%b instr=%h, want 1 0f0", write_en, INSTRUCTION);
    end
    tick(); tick(); tick();
    checks++;
    if ((we_cnt - base) !== 1 || FIFO_COUNT !== 3'd0 || INSTRUCTION !== 9'h0F0) begin
      errors++;
      $display("FAIL sync_only: got pulses=%0d cnt=%0d instr=%h, want 1 0 0f0",
               we_cnt - base, FIFO_COUNT, INSTRUCTION);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    shift_frame(9'h0AB, 1'b0);
    shift_frame(9'h0CD, 1'b0);
    shift_raw(10'b1011, 4);
    checks++;
    if (FIFO_COUNT !== 3'd2) begin
      errors++;
      $display("FAIL mid_buffered: got cnt=%0d, want 2", FIFO_COUNT);
    end
    CPU_READY = 1'b1;
    RESET_N   = 1'b0;
    #2;
    checks++;
    if ({INSTRUCTION, write_en, FIFO_COUNT, FULL, OVERFLOW, PAR_ERR} !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async_reset: got instr=%h we=%b cnt=%0d full=%b ovf=%b perr=%b, want all 0",
               INSTRUCTION, write_en, FIFO_COUNT, FULL, OVERFLOW, PAR_ERR);
    end
    tick();
    base = we_cnt;
    RESET_N = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ((we_cnt - base) !== 0 || FIFO_COUNT !== 3'd0) begin
      errors++;
      $display("FAIL mid_no_issue: got pulses=%0d cnt=%0d, want 0 0", we_cnt - base, FIFO_COUNT);
    end
    shift_frame(9'h0AA, 1'b0);
    tick();
    checks++;
    if (write_en !== 1'b1 || INSTRUCTION !== 9'h0AA) begin
      errors++;
      $display("FAIL mid_fresh_frame: got we=%b instr=%h, want 1 0aa", write_en, INSTRUCTION);
    end
  endtask

`ifdef LOADER_PARITY_EN
  task automatic test_parity();
    int base;
    do_reset();
    CPU_READY = 1'b1;
    base = we_cnt;
    shift_raw({9'h001, 1'b0}, 10);
    shift_raw({9'h001, 1'b1}, 10);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ((we_cnt - base) !== 1 || INSTRUCTION !== 9'h001 || PAR_ERR !== 1'b1 || OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL parity: got pulses=%0d instr=%h perr=%b ovf=%b, want 1 001 1 0",
               we_cnt - base, INSTRUCTION, PAR_ERR, OVERFLOW);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_frame_sync();
    test_reset_midframe();
`ifdef LOADER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
